// File: rtl/clah_digit_serial_adder.sv
// ---------------------------------------------------------------------------
// clah_digit_serial_adder
//
// Multi-cycle carry look-ahead adder. It adds two WIDTH-bit unsigned operands
// plus a carry-in, processing DIGIT bits per clock. Each RUN cycle, one digit
// slice forms generate/propagate terms and resolves every in-digit carry in
// flattened look-ahead form from the registered carry. The digit carry-out is
// registered and feeds the next digit.
//
// Parameters:
//   WIDTH : operand and sum width; must be an integer multiple of DIGIT
//   DIGIT : bits processed per clock (N = WIDTH/DIGIT digit cycles)
//
// Ports:
//   clk   : clock; all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   start : request, sampled only while idle
//   a, b  : operands, captured when start is accepted
//   cin   : carry-in to bit 0, captured when start is accepted
//   busy  : high while digits are being processed
//   done  : one-cycle completion pulse
//   sum   : registered result, held until the next completion
//   cout  : registered carry-out of bit WIDTH-1
// ---------------------------------------------------------------------------
module clah_digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [WIDTH-1:0] psum_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic [DIGIT-1:0]       g_s;
    logic [DIGIT-1:0]       p_s;
    logic [DIGIT:0]         c_s;
    logic [DIGIT-1:0]       sum_dig_s;
    logic [WIDTH+DIGIT-1:0] cat_s;
    logic [WIDTH-1:0]       psum_next_s;
    logic                   last_s;
    logic                   term_s;
    logic                   cj_s;

    // The operand registers shift right each cycle, so the active digit is
    // always the low DIGIT bits; no variable indexing is needed.
    assign g_s = a_r[DIGIT-1:0] & b_r[DIGIT-1:0];
    assign p_s = a_r[DIGIT-1:0] ^ b_r[DIGIT-1:0];

    // Look-ahead carries: c[j+1] = OR_k (g[k] & p[k+1..j]) | (p[0..j] & c0),
    // expanded as a flat sum of products per carry rather than a ripple chain.
    always_comb begin
        c_s    = '0;
        term_s = 1'b0;
        cj_s   = 1'b0;
        c_s[0] = carry_r;
        for (int j = 0; j < DIGIT; j++) begin
            cj_s = 1'b0;
            for (int k = 0; k <= j; k++) begin
                term_s = g_s[k];
                for (int m = k + 1; m <= j; m++) begin
                    term_s = term_s & p_s[m];
                end
                cj_s = cj_s | term_s;
            end
            term_s = carry_r;
            for (int m = 0; m <= j; m++) begin
                term_s = term_s & p_s[m];
            end
            c_s[j+1] = cj_s | term_s;
        end
    end

    assign sum_dig_s = p_s ^ c_s[DIGIT-1:0];

    // The new digit enters at the top of the partial sum, which shifts right.
    // After N digits, digit 0 has reached bit 0.
    assign cat_s       = {sum_dig_s, psum_r};
    assign psum_next_s = cat_s[WIDTH+DIGIT-1:DIGIT];
    assign last_s      = (cnt_r == CNT_W'(N - 1));

    // Control FSM and datapath registers: capture, digit processing, completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            psum_r  <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        psum_r  <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= c_s[DIGIT];
                    psum_r  <= psum_next_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        sum_r   <= psum_next_s;
                        cout_r  <= c_s[DIGIT];
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_clah_digit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_clah_digit_serial_adder
//
// Directed and randomized bench for clah_digit_serial_adder (WIDTH=16,
// DIGIT=4). Expected results come from plain integer addition; the timing of
// busy/done is taken from the cycle-level protocol (N+1 latency, N+2 issue).
// ---------------------------------------------------------------------------
module tb_clah_digit_serial_adder;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           n_cmp;
    int           n_fail;
    logic [W-1:0] held_sum;
    logic         held_cout;

    clah_digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one operation from idle and follow it until idle again.
    // scramble keeps start high and changes a/b every cycle while running.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tc, input bit scramble);
        logic [W:0] expv;
        expv  = {1'b0, ta} + {1'b0, tbv} + {{W{1'b0}}, tc};
        a     = ta;
        b     = tbv;
        cin   = tc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = scramble ? 1'b1 : 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk({tag, ":busy_run"}, {31'd0, busy}, 32'd1);
            chk({tag, ":done_run"}, {31'd0, done}, 32'd0);
            chk({tag, ":sum_held"}, {16'd0, sum}, {16'd0, held_sum});
            chk({tag, ":cout_held"}, {31'd0, cout}, {31'd0, held_cout});
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        @(negedge clk);
        chk({tag, ":done"}, {31'd0, done}, 32'd1);
        chk({tag, ":busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, ":sum"}, {16'd0, sum}, {16'd0, expv[W-1:0]});
        chk({tag, ":cout"}, {31'd0, cout}, {31'd0, expv[W]});
        held_sum  = expv[W-1:0];
        held_cout = expv[W];
        @(negedge clk);
        chk({tag, ":done_clr"}, {31'd0, done}, 32'd0);
        chk({tag, ":busy_idle"}, {31'd0, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk({tag, ":no_reissue"}, {31'd0, busy}, 32'd0);
        chk({tag, ":sum_keep"}, {16'd0, sum}, {16'd0, held_sum});
    endtask

    initial begin
        int pulses;
        int last_pulse;
        n_cmp     = 0;
        n_fail    = 0;
        held_sum  = '0;
        held_cout = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0);
        do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op("t3a", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        do_op("t3b", 16'h0000, 16'h0000, 1'b1, 1'b0);
        do_op("t4", 16'h00F0, 16'h0010, 1'b0, 1'b1);

        // Reset in the middle of an operation aborts it.
        a     = 16'h8000;
        b     = 16'h8000;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_sum", {16'd0, sum}, 32'd0);
        chk("t5_cout", {31'd0, cout}, 32'd0);
        held_sum  = '0;
        held_cout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk("t5_no_done", {31'd0, done}, 32'd0);
        end
        do_op("t5b", 16'h0003, 16'h0004, 1'b0, 1'b0);

        // Random operands against integer addition.
        for (int i = 0; i < 8; i++) begin
            do_op("rnd", W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        // start held high: a completion every N+2 cycles, result held between.
        a          = 16'h0101;
        b          = 16'h1010;
        cin        = 1'b0;
        start      = 1'b1;
        pulses     = 0;
        last_pulse = -1;
        for (int cyc = 1; cyc <= 3 * (N + 2); cyc++) begin
            @(negedge clk);
            if (done) begin
                chk("t6_sum", {16'd0, sum}, 32'h0000_1111);
                chk("t6_cout", {31'd0, cout}, 32'd0);
                chk("t6_busy", {31'd0, busy}, 32'd0);
                if (last_pulse >= 0) begin
                    chk("t6_interval", cyc - last_pulse, N + 2);
                end else begin
                    chk("t6_first", cyc, N + 1);
                end
                last_pulse = cyc;
                pulses++;
            end else if (pulses > 0) begin
                chk("t6_hold", {16'd0, sum}, 32'h0000_1111);
            end
        end
        start = 1'b0;
        chk("t6_pulses", pulses, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
